// File: rtl/pdm_ctrl_pkg.sv
// Shared types and widths for the PDM record/playback controller.
package pdm_ctrl_pkg;

    localparam int WORD_W    = 16;
    localparam int BIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        LOAD   = 2'd2,
        PLAY   = 2'd3
    } state_t;

endpackage

// File: rtl/pdm_clk_gen.sv
// Microphone clock divider: mclk = clk / (2*CLK_DIV), tick marks each mclk rise.
module pdm_clk_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic mclk,
    output logic tick
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            mclk <= 1'b0;
            tick <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            mclk <= 1'b0;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (cnt == CNT_MAX) begin
                cnt  <= '0;
                mclk <= ~mclk;
                // tick is registered alongside mclk so both are high in the same cycle
                tick <= ~mclk;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pdm_audio_ctrl.sv
// Record/playback sequencer: packs PDM mic bits into 16-bit RAM words and
// replays them MSB-first onto the amplifier pin.
module pdm_audio_ctrl
    import pdm_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 50,
    parameter int ADDR_W  = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rec_req,
    input  logic              play_req,
    input  logic              stop_req,
    input  logic              micData,
    output logic              mclk,
    output logic              micLRSel,
    output logic              ampPWM,
    output logic              ampSD,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [1:0]        state,
    output logic              done
);
    state_t st, st_nxt;

    logic                 tick;
    logic                 fin;
    logic                 load_rdy;
    logic                 rec_last;
    logic                 play_last;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [WORD_W-1:0]    sreg;
    logic [WORD_W-1:0]    pword;
    logic [ADDR_W:0]      rec_len;
    logic [ADDR_W:0]      word_cnt;

    pdm_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk  (clk),
        .reset(reset),
        .en   (st != IDLE),
        .mclk (mclk),
        .tick (tick)
    );

    assign micLRSel  = 1'b0;
    assign state     = st;
    assign rec_last  = mem_we && (mem_addr == '1);
    assign play_last = tick && (bit_cnt == '1) && (word_cnt == rec_len);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) st <= IDLE;
        else       st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        fin    = 1'b0;
        case (st)
            IDLE: begin
                if (!stop_req) begin
                    if (rec_req)                         st_nxt = RECORD;
                    else if (play_req && rec_len != '0)  st_nxt = LOAD;
                end
            end
            RECORD:  if (stop_req || rec_last)  st_nxt = IDLE;
            LOAD: begin
                if (stop_req)      st_nxt = IDLE;
                else if (load_rdy) st_nxt = PLAY;
            end
            PLAY:    if (stop_req || play_last) st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
        fin = (st != IDLE) && (st_nxt == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done      <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ampPWM    <= 1'b0;
            ampSD     <= 1'b0;
            bit_cnt   <= '0;
            sreg      <= '0;
            pword     <= '0;
            rec_len   <= '0;
            word_cnt  <= '0;
            load_rdy  <= 1'b0;
        end else begin
            done   <= fin;
            mem_we <= 1'b0;
            ampSD  <= (st == PLAY);
            if (st != PLAY) ampPWM <= 1'b0;

            // A strobed write always lands, even if stop arrives in that cycle
            if (mem_we) begin
                mem_addr <= mem_addr + 1'b1;
                rec_len  <= rec_len + 1'b1;
            end

            case (st)
                IDLE: begin
                    if (st_nxt == RECORD) begin
                        mem_addr <= '0;
                        bit_cnt  <= '0;
                        sreg     <= '0;
                        rec_len  <= '0;
                    end else if (st_nxt == LOAD) begin
                        mem_addr <= '0;
                        load_rdy <= 1'b0;
                    end
                end
                RECORD: begin
                    if (tick && !stop_req) begin
                        sreg    <= {sreg[WORD_W-2:0], micData};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == '1) begin
                            mem_wdata <= {sreg[WORD_W-2:0], micData};
                            mem_we    <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    load_rdy <= 1'b1;
                    if (st_nxt == PLAY) begin
                        pword    <= mem_rdata;
                        mem_addr <= ADDR_W'(1);
                        bit_cnt  <= '0;
                        word_cnt <= {{ADDR_W{1'b0}}, 1'b1};
                    end
                end
                PLAY: begin
                    if (tick) begin
                        ampPWM  <= pword[BIT_CNT_W'(WORD_W - 1) - bit_cnt];
                        bit_cnt <= bit_cnt + 1'b1;
                        // Next word was addressed a full word earlier, so rdata is settled
                        if (bit_cnt == '1 && word_cnt != rec_len) begin
                            pword    <= mem_rdata;
                            mem_addr <= mem_addr + 1'b1;
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_audio_ctrl.sv
// Bench for pdm_audio_ctrl: closed-form timing model checked every cycle,
// plus literal checks on recorded words and replayed bitstreams.
module tb_pdm_audio_ctrl;
    localparam int D  = 2;
    localparam int AW = 3;
    localparam int NW = 8;

    logic clk = 1'b0;
    logic reset, rec_req, play_req, stop_req;
    logic micData = 1'b0;
    logic mclk, micLRSel, ampPWM, ampSD, mem_we, done;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata, mem_rdata;
    logic [1:0]    state;

    pdm_audio_ctrl #(.CLK_DIV(D), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .rec_req(rec_req), .play_req(play_req),
        .stop_req(stop_req), .micData(micData), .mclk(mclk), .micLRSel(micLRSel),
        .ampPWM(ampPWM), .ampSD(ampSD), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .state(state), .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous RAM with a bench-side preload port
    logic [15:0]   ram [NW];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [15:0]   bd_data = '0;
    always @(posedge clk) begin
        if (bd_we)       ram[bd_addr]  <= bd_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0, miscompares = 0;
    int done_cnt = 0, we_cnt = 0;
    logic chk_en = 1'b0;

    // Model: op kind (0 none, 1 record, 2 play), entry cycle, cycle state returns to IDLE
    int m_mode = 0, m_t0 = 0, m_end = 0, m_len = 0;
    logic [15:0] m_mem [NW];
    logic [15:0] pat = 16'hA5C3;
    bit pwm_cap [256];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp_v);
        end
    endtask

    function automatic int tick_cyc(input int n);
        return m_t0 + D * (2 * n - 1);
    endfunction

    function automatic logic mic_bit(input int n);
        logic [15:0] p;
        p = pat;
        return p[15 - ((n - 1) % 16)];
    endfunction

    function automatic logic [15:0] exp_word(input int k);
        logic [15:0] w;
        for (int j = 0; j < 16; j++) w[15-j] = mic_bit(16 * (k - 1) + j + 1);
        return w;
    endfunction

    function automatic logic play_bit(input int n);
        logic [15:0] wd;
        wd = m_mem[(n - 1) / 16];
        return wd[15 - ((n - 1) % 16)];
    endfunction

    // Mic data for the tick falling within the current mclk period
    always @(posedge clk) begin
        #1;
        if (m_mode == 1 && cyc >= m_t0) micData = mic_bit((cyc - m_t0) / (2 * D) + 1);
        else                            micData = 1'b0;
    end

    always @(negedge clk) begin
        int c, r, n, k;
        logic [1:0] e_state;
        logic e_done, e_mclk, e_we, e_sd, e_pwm;
        if (chk_en) begin
            c = cyc;
            r = c - m_t0;
            e_state = 2'd0;
            if (m_mode != 0 && c >= m_t0 && c < m_end)
                e_state = (m_mode == 1) ? 2'd1 : ((r < 2) ? 2'd2 : 2'd3);
            e_done = (m_mode != 0) && (c == m_end);
            e_mclk = (m_mode != 0 && c >= m_t0 && c <= m_end) ? ((r / D) % 2 == 1) : 1'b0;
            e_we = 1'b0;
            k = 0;
            if (m_mode == 1 && c < m_end && r > 1 && (r - 1) % D == 0) begin
                n = (r - 1) / D + 1;
                if (n % 2 == 0 && (n / 2) % 16 == 0) begin
                    e_we = 1'b1;
                    k = n / 32;
                end
            end
            e_sd = (m_mode == 2) && (c >= m_t0 + 3) && (c <= m_end);
            e_pwm = 1'b0;
            if (e_sd) begin
                n = (r - 1 + D) / (2 * D);
                if (n > 0) e_pwm = play_bit(n);
            end
            if (m_mode == 2 && c <= m_end && r > 1 && (r - 1) % D == 0 && ((r - 1) / D + 1) % 2 == 0) begin
                n = ((r - 1) / D + 1) / 2;
                if (n >= 1 && n <= 256) pwm_cap[n-1] = ampPWM;
            end
            chk("state", 32'(state), 32'(e_state));
            chk("done", 32'(done), 32'(e_done));
            chk("mclk", 32'(mclk), 32'(e_mclk));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("ampSD", 32'(ampSD), 32'(e_sd));
            chk("ampPWM", 32'(ampPWM), 32'(e_pwm));
            chk("micLRSel", 32'(micLRSel), 32'd0);
            if (e_we) begin
                chk("mem_addr", 32'(mem_addr), 32'(k - 1));
                chk("mem_wdata", 32'(mem_wdata), 32'(exp_word(k)));
            end
            if (done)   done_cnt++;
            if (mem_we) we_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_record(input int stop_tick, input bit stop_on_last, input int exp_we);
        int s, d0, w0;
        d0 = done_cnt;
        w0 = we_cnt;
        m_mode = 1;
        m_t0 = cyc + 1;
        m_end = tick_cyc(16 * NW) + 2;
        s = -1;
        if (stop_tick > 0)     s = tick_cyc(stop_tick) + 1;
        else if (stop_on_last) s = m_end - 1;
        if (s >= 0 && s + 1 < m_end) m_end = s + 1;
        rec_req = 1'b1;
        step(1);
        rec_req = 1'b0;
        if (s >= 0) begin
            step(s - cyc);
            stop_req = 1'b1;
            step(1);
            stop_req = 1'b0;
        end
        step(m_end + 4 - cyc);
        m_len = 0;
        for (int k = 1; k <= NW; k++) begin
            if (tick_cyc(16 * k) + 1 < m_end) begin
                m_mem[k-1] = exp_word(k);
                m_len++;
            end
        end
        chk("rec_we_count", 32'(we_cnt - w0), 32'(exp_we));
        chk("rec_done_count", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic do_play(input bit inject_rec, input int reset_at);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 256; i++) pwm_cap[i] = 1'b0;
        m_mode = 2;
        m_t0 = cyc + 1;
        m_end = tick_cyc(16 * m_len) + 1;
        play_req = 1'b1;
        step(1);
        play_req = 1'b0;
        if (inject_rec) begin
            step(40);
            rec_req = 1'b1;
            step(1);
            rec_req = 1'b0;
        end
        if (reset_at > 0) begin
            step(reset_at);
            #2;
            chk_en = 1'b0;
            reset = 1'b1;
            #1;
            chk("rst_ampSD", 32'(ampSD), 32'd0);
            chk("rst_ampPWM", 32'(ampPWM), 32'd0);
            chk("rst_mclk", 32'(mclk), 32'd0);
            chk("rst_state", 32'(state), 32'd0);
            @(posedge clk);
            #1;
            reset = 1'b0;
            m_mode = 0;
            m_len = 0;
            chk_en = 1'b1;
            play_req = 1'b1;
            step(1);
            play_req = 1'b0;
            step(20);
            chk("play_after_reset", 32'(state), 32'd0);
        end else begin
            step(m_end + 4 - cyc);
            chk("play_done_count", 32'(done_cnt - d0), 32'd1);
        end
    endtask

    initial begin
        logic [31:0] bits32;
        logic [15:0] bits16;
        reset = 1'b1;
        rec_req = 1'b0;
        play_req = 1'b0;
        stop_req = 1'b0;
        step(3);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_mclk", 32'(mclk), 32'd0);
        chk("reset_ampSD", 32'(ampSD), 32'd0);
        chk("reset_ampPWM", 32'(ampPWM), 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        chk("reset_mem_wdata", 32'(mem_wdata), 32'd0);
        reset = 1'b0;
        m_mode = 0;
        chk_en = 1'b1;
        step(3);

        // play with nothing recorded, then simultaneous stop+rec in IDLE
        play_req = 1'b1;
        step(1);
        play_req = 1'b0;
        step(10);
        chk("empty_play_ignored", 32'(state), 32'd0);
        stop_req = 1'b1;
        rec_req = 1'b1;
        step(1);
        stop_req = 1'b0;
        rec_req = 1'b0;
        step(10);
        chk("stop_rec_idle", 32'(state), 32'd0);

        do_record(0, 1'b0, 8);
        for (int i = 0; i < NW; i++) chk("ram_word", 32'(ram[i]), 32'h0000_A5C3);

        do_play(1'b1, 0);
        for (int i = 0; i < 16; i++) bits16[15-i] = pwm_cap[i];
        chk("play8_first_word", 32'(bits16), 32'h0000_A5C3);
        for (int i = 0; i < 16; i++) bits16[15-i] = pwm_cap[112+i];
        chk("play8_last_word", 32'(bits16), 32'h0000_A5C3);

        do_record(40, 1'b0, 2);
        step(5);
        chk("stop_mclk_low", 32'(mclk), 32'd0);

        bd_we = 1'b1;
        bd_addr = 3'd0;
        bd_data = 16'h8001;
        step(1);
        bd_addr = 3'd1;
        bd_data = 16'hFFFF;
        step(1);
        bd_we = 1'b0;
        m_mem[0] = 16'h8001;
        m_mem[1] = 16'hFFFF;
        step(2);
        do_play(1'b0, 0);
        for (int i = 0; i < 32; i++) bits32[31-i] = pwm_cap[i];
        chk("play2_stream", bits32, 32'h8001_FFFF);

        do_record(0, 1'b1, 8);
        do_play(1'b0, 30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, vectors %0d", vectors);
        $fatal(1);
    end

endmodule
